// File: rtl/game_bg_scroll.sv
// rtl/game_bg_scroll.sv - vertically scrolling, up-scaled, wrap-around tiled background renderer
// Incremental address counters drive an external 1-cycle ROM; colour lands 2 cycles after h_cnt/v_cnt.
module game_bg_scroll #(
    parameter int IMG_W   = 213,
    parameter int IMG_H   = 160,
    parameter int SCALE_X = 3,
    parameter int SCALE_Y = 3,
    parameter int H_START = 144,
    parameter int V_START = 35,
    parameter int ADDR_W  = 16,
    parameter int ROW_W   = 8
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              pause,
    input  logic [3:0]        speed,
    input  logic [11:0]       h_cnt,
    input  logic [11:0]       v_cnt,
    input  logic              active,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [ROW_W-1:0]  scroll_pos,
    output logic [3:0]        bg_red,
    output logic [3:0]        bg_green,
    output logic [3:0]        bg_blue,
    output logic              bg_active
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int XS_W  = $clog2(SCALE_X + 1);
    localparam int YS_W  = $clog2(SCALE_Y + 1);
    localparam int SUM_W = ((ROW_W > 4) ? ROW_W : 4) + 1;

    localparam logic [11:0]       H_LO     = 12'(H_START);
    localparam logic [11:0]       H_HI     = 12'(H_START + IMG_W * SCALE_X - 1);
    localparam logic [11:0]       V_LO     = 12'(V_START);
    localparam logic [11:0]       V_HI     = 12'(V_START + IMG_H * SCALE_Y - 1);
    localparam logic [ADDR_W:0]   IMG_SIZE = (ADDR_W + 1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic in_win;
    logic line_end;
    logic frame_start;
    logic do_step;

    assign in_win = active
                 && (h_cnt >= H_LO) && (h_cnt <= H_HI)
                 && (v_cnt >= V_LO) && (v_cnt <= V_HI);
    assign line_end    = in_win && (h_cnt == H_HI);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign do_step     = frame_start && ena && !pause;

    // scroll_base always equals scroll_pos*IMG_W, so the frame-start reload needs no multiplier on row
    logic [ADDR_W-1:0] scroll_base;
    logic [SUM_W-1:0]  scroll_sum;
    logic [ROW_W-1:0]  scroll_next;
    logic [ADDR_W:0]   spd_base;
    logic [ADDR_W:0]   base_sum;
    logic [ADDR_W-1:0] base_next;
    logic              wrap;

    always_comb begin
        scroll_sum  = SUM_W'(scroll_pos) + SUM_W'(speed);
        wrap        = scroll_sum >= SUM_W'(IMG_H);
        scroll_next = wrap ? ROW_W'(scroll_sum - SUM_W'(IMG_H)) : ROW_W'(scroll_sum);
        spd_base    = (ADDR_W + 1)'(speed) * (ADDR_W + 1)'(IMG_W);
        base_sum    = {1'b0, scroll_base} + spd_base;
        base_next   = wrap ? ADDR_W'(base_sum - IMG_SIZE) : ADDR_W'(base_sum);
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            scroll_pos  <= '0;
            scroll_base <= '0;
        end else if (do_step) begin
            scroll_pos  <= scroll_next;
            scroll_base <= base_next;
        end
    end

    logic [XS_W-1:0]   x_sub;
    logic [COL_W-1:0]  col;
    logic [YS_W-1:0]   y_sub;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic              synced;

    // synced keeps a reset taken mid-frame from rendering with stale row state
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            x_sub    <= '0;
            col      <= '0;
            y_sub    <= '0;
            row      <= '0;
            row_base <= '0;
            synced   <= 1'b0;
        end else begin
            if (in_win) begin
                if (x_sub == XS_W'(SCALE_X - 1)) begin
                    x_sub <= '0;
                    col   <= col + 1'b1;
                end else begin
                    x_sub <= x_sub + 1'b1;
                end
            end else begin
                x_sub <= '0;
                col   <= '0;
            end

            if (frame_start) begin
                synced   <= 1'b1;
                y_sub    <= '0;
                row      <= do_step ? scroll_next : scroll_pos;
                row_base <= do_step ? base_next : scroll_base;
            end else if (line_end) begin
                if (y_sub == YS_W'(SCALE_Y - 1)) begin
                    y_sub <= '0;
                    if (row == ROW_W'(IMG_H - 1)) begin
                        row      <= '0;
                        row_base <= '0;
                    end else begin
                        row      <= row + 1'b1;
                        row_base <= row_base + ROW_STEP;
                    end
                end else begin
                    y_sub <= y_sub + 1'b1;
                end
            end
        end
    end

    logic valid0;
    logic valid1;

    assign rom_en = valid0;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rom_addr  <= '0;
            valid0    <= 1'b0;
            valid1    <= 1'b0;
            bg_red    <= '0;
            bg_green  <= '0;
            bg_blue   <= '0;
            bg_active <= 1'b0;
        end else begin
            rom_addr  <= row_base + ADDR_W'(col);
            valid0    <= in_win && ena && synced;
            valid1    <= valid0;
            bg_red    <= valid1 ? rom_data[15:12] : 4'h0;
            bg_green  <= valid1 ? rom_data[10:7]  : 4'h0;
            bg_blue   <= valid1 ? rom_data[4:1]   : 4'h0;
            bg_active <= valid1;
        end
    end

    logic unused_lsbs;
    assign unused_lsbs = ^{rom_data[11], rom_data[6:5], rom_data[0]};

endmodule

// File: doc/game_bg_scroll.md
Name: game_bg_scroll

Overview:
Parametrised, vertically scrolling background renderer for the plane-war VGA pipeline. Maps the timing generator's h_cnt/v_cnt onto an up-scaled, wrap-around tiled background image and drives an external RGB565 ROM port. The scroll offset advances once per frame with programmable speed and pause. Replaces the divide-based address path with incremental counters and returns colour and bg_active pixel-aligned with a fixed pipeline latency.

Parameters:
IMG_W, 213, image width in source pixels
IMG_H, 160, image height in source pixels
SCALE_X, 3, horizontal replication factor (>=1)
SCALE_Y, 3, vertical replication factor (>=1)
H_START, 144, first displayed h_cnt (sync + back porch)
V_START, 35, first displayed v_cnt (sync + back porch)
ADDR_W, 16, ROM address width; IMG_W*IMG_H <= 2^ADDR_W
ROW_W, 8, width of scroll offset; IMG_H <= 2^ROW_W

Ports:
vga_clk  in  1  pixel clock, 25.175 MHz
rst  in  1  synchronous reset, active-high
ena  in  1  block enable; low blanks output and freezes scrolling
pause  in  1  freeze scroll offset while high
speed  in  4  rows added to scroll offset per frame
h_cnt  in  12  horizontal timing position
v_cnt  in  12  vertical timing position
active  in  1  timing generator display-active flag
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM address, row-major, 1-cycle read latency
rom_data  in  16  RGB565 pixel from ROM
scroll_pos  out  ROW_W  current top row of image (0..IMG_H-1)
bg_red  out  4  red, rom_data[15:12]
bg_green  out  4  green, rom_data[10:7]
bg_blue  out  4  blue, rom_data[4:1]
bg_active  out  1  background pixel valid

Behaviour:
- Reset (synchronous, vga_clk edge with rst=1): all outputs 0, scroll_pos=0, all internal counters/pipeline flags 0. Reset mid-line/mid-frame takes effect on that edge; rendering resumes cleanly at next frame start.
- in_win = active && H_START <= h_cnt <= H_START+IMG_W*SCALE_X-1 && V_START <= v_cnt <= V_START+IMG_H*SCALE_Y-1.
- Frame start = (h_cnt==0 && v_cnt==0). On that cycle: if ena && !pause, scroll_pos <= (scroll_pos+speed) mod IMG_H (speed<IMG_H; single conditional subtract); load row=new scroll_pos, row_base=row*IMG_W (computed by the same update: row_base tracks scroll_pos via add/subtract of speed*IMG_W or sequential accumulation completed before V_START), y_sub=0.
- Horizontal: x_sub counts 0..SCALE_X-1 on each in_win cycle; col increments when x_sub wraps; col and x_sub clear when h_cnt leaves window.
- Vertical: at last in_win pixel of a line, y_sub increments; on wrap past SCALE_Y-1, row increments and row_base += IMG_W; row==IMG_H-1 wraps to row=0, row_base=0 (seamless tiling).
- Stage 0 (cycle N): rom_addr <= row_base+col, rom_en <= in_win && ena, valid0 <= in_win && ena.
- Stage 1 (N+1): ROM returns data; valid1 <= valid0.
- Stage 2 (N+2): colour <= valid1 ? fields of rom_data : 0; bg_active <= valid1. Total latency from h_cnt to colour = 2 cycles, constant.
- ena low: rom_en=0, colour/bg_active forced 0 through pipeline; position counters keep tracking timing; scroll_pos holds.
- speed=0 or pause: static image; pause and ena are sampled only at frame start.
- Address arithmetic: row_base+col <= IMG_W*IMG_H-1, no overflow in ADDR_W.

Test Plan:
- Reset: hold rst 3 cycles mid-frame -> all outputs 0, scroll_pos=0; next frame first window pixel rom_addr=0.
- Static image, speed=0: pixel (h=H_START+3, v=V_START) -> rom_addr=1; (H_START, V_START+3) -> rom_addr=213; colour from rom_data=16'hF81F appears 2 cycles after address as red=F, green=0, blue=F, bg_active=1.
- Window edge: h_cnt=H_START+638 -> bg_active 1 (2 cycles later); h_cnt=H_START+639 -> bg_active 0, colour 0; v_cnt=V_START+480 -> no rom_en.
- Scroll: speed=5, two frames -> scroll_pos=10; first window pixel rom_addr=2130; after 150 image rows, row wraps, rom_addr returns to 0.
- Wrap of offset: scroll_pos=158, speed=5 -> next frame scroll_pos=3; pause=1 at frame start -> scroll_pos unchanged.
- ena=0 for one frame: bg_active=0, rom_en=0 throughout, scroll_pos unchanged; ena=1 restores output at next window pixel.
